// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Host target-duty request channel (valid/ready) for the PWM duty ramp controller.
interface pwm_duty_ramp_ctrl_if #(
    parameter int unsigned DUTY_W = 4
);
    logic              tgt_valid;
    logic              tgt_ready;
    logic [DUTY_W-1:0] tgt_duty;

    modport master (output tgt_valid, output tgt_duty, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_duty, output tgt_ready);
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Ramps the PWM duty one step at a time toward a host or button-nudged target,
// changing the applied duty only on PWM period boundaries.
module pwm_duty_ramp_ctrl #(
    parameter int unsigned DUTY_W       = 4,
    parameter int unsigned PERIOD       = 10,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned INIT_DUTY    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 period_start,
    pwm_duty_ramp_ctrl_if.slave  host,
    input  logic                 inc_pulse,
    input  logic                 dec_pulse,
    input  logic                 abort,
    output logic [DUTY_W-1:0]    duty_cycle,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned DW1  = DUTY_W + 1;
    localparam int unsigned CntW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [DW1-1:0]  PeriodX  = DW1'(PERIOD);
    localparam logic [CntW-1:0] StepLast = CntW'(STEP_PERIODS - 1);

    typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_e;

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              req;
    logic [DW1-1:0]    duty_x;
    logic [DW1-1:0]    host_x;
    logic [DW1-1:0]    new_tgt;
    logic [DW1-1:0]    step_x;

    assign host.tgt_ready = (state_q == StIdle) & ~abort & ~rst;

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        req      = 1'b0;
        duty_x   = {1'b0, duty_q};
        host_x   = {1'b0, host.tgt_duty};
        new_tgt  = {1'b0, target_q};
        step_x   = duty_x;

        if (abort) begin
            // Freeze where we are; the pending ramp is discarded.
            state_d  = StIdle;
            target_d = duty_q;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (host.tgt_valid && host.tgt_ready) begin
                        req     = 1'b1;
                        new_tgt = (host_x > PeriodX) ? PeriodX : host_x;
                    end else if (inc_pulse ^ dec_pulse) begin
                        req = 1'b1;
                        if (inc_pulse) begin
                            new_tgt = (duty_x >= PeriodX) ? PeriodX : duty_x + DW1'(1);
                        end else begin
                            new_tgt = (duty_x == '0) ? '0 : duty_x - DW1'(1);
                        end
                    end

                    if (req) begin
                        target_d = new_tgt[DUTY_W-1:0];
                        cnt_d    = '0;
                        if (new_tgt > duty_x) begin
                            state_d = StRampUp;
                        end else if (new_tgt < duty_x) begin
                            state_d = StRampDown;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end

                StRampUp, StRampDown: begin
                    if (period_start) begin
                        if (cnt_q == StepLast) begin
                            cnt_d  = '0;
                            step_x = (state_q == StRampUp) ? duty_x + DW1'(1)
                                                           : duty_x - DW1'(1);
                            duty_d = step_x[DUTY_W-1:0];
                            if (step_x == {1'b0, target_q}) begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end

                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            duty_q   <= DUTY_W'(INIT_DUTY);
            target_q <= DUTY_W'(INIT_DUTY);
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign duty_cycle = duty_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl: period_start every 10 clocks, one task per scenario.
module tb_pwm_duty_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       period_start = 1'b0;
    logic       inc_pulse = 1'b0;
    logic       dec_pulse = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] duty_cycle;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    pwm_duty_ramp_ctrl_if #(.DUTY_W(4)) hif ();

    pwm_duty_ramp_ctrl #(
        .DUTY_W(4), .PERIOD(10), .STEP_PERIODS(4), .INIT_DUTY(5)
    ) dut (
        .clk(clk), .rst(rst), .period_start(period_start), .host(hif),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .abort(abort),
        .duty_cycle(duty_cycle), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // One clock; also checks that duty only moves on period_start edges outside reset.
    task automatic cyc();
        logic [3:0] prev_duty;
        logic       prev_ps;
        logic       prev_rst;
        prev_duty = duty_cycle;
        prev_ps   = period_start;
        prev_rst  = rst;
        @(posedge clk);
        #1;
        if (!prev_rst && !prev_ps) begin
            checks++;
            if (duty_cycle !== prev_duty) begin
                failures++;
                $display("FAIL duty_stable: got %0d required %0d (no period_start)",
                         duty_cycle, prev_duty);
            end
        end
    endtask

    // Nine quiet clocks then one clock with period_start high.
    task automatic period();
        period_start = 1'b0;
        repeat (9) cyc();
        period_start = 1'b1;
        cyc();
        period_start = 1'b0;
    endtask

    task automatic host_req(input logic [3:0] d);
        hif.tgt_valid = 1'b1;
        hif.tgt_duty  = d;
        cyc();
        hif.tgt_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if (hif.tgt_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_low: got %b required 0", hif.tgt_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({duty_cycle, busy, done, hif.tgt_ready} !== {4'd5, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got duty=%0d busy=%b done=%b ready=%b required 5/0/0/1",
                     duty_cycle, busy, done, hif.tgt_ready);
        end
    endtask

    task automatic test_ramp_up();
        logic [3:0] exp_d;
        host_req(4'd8);
        checks++;
        if ({duty_cycle, busy, done} !== {4'd5, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL up_accept: got duty=%0d busy=%b done=%b required 5/1/0",
                     duty_cycle, busy, done);
        end
        for (int p = 1; p <= 12; p++) begin
            period();
            exp_d = 4'(5 + p / 4);
            checks++;
            if ({duty_cycle, busy, done} !== {exp_d, (p < 12), (p == 12)}) begin
                failures++;
                $display("FAIL up_p%0d: got duty=%0d busy=%b done=%b required %0d/%b/%b",
                         p, duty_cycle, busy, done, exp_d, (p < 12), (p == 12));
            end
        end
        cyc();
        checks++;
        if ({duty_cycle, busy, done} !== {4'd8, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL up_after: got duty=%0d busy=%b done=%b required 8/0/0",
                     duty_cycle, busy, done);
        end
    endtask

    task automatic test_ramp_down_clamp();
        logic [3:0] exp_d;
        host_req(4'd15);
        for (int p = 1; p <= 8; p++) begin
            period();
            exp_d = 4'(8 + p / 4);
            checks++;
            if ({duty_cycle, done} !== {exp_d, (p == 8)}) begin
                failures++;
                $display("FAIL clamp_p%0d: got duty=%0d done=%b required %0d/%b",
                         p, duty_cycle, done, exp_d, (p == 8));
            end
        end
        cyc();
        host_req(4'd0);
        for (int p = 1; p <= 40; p++) begin
            period();
            exp_d = 4'(10 - p / 4);
            checks++;
            if ({duty_cycle, busy, done} !== {exp_d, (p < 40), (p == 40)}) begin
                failures++;
                $display("FAIL down_p%0d: got duty=%0d busy=%b done=%b required %0d/%b/%b",
                         p, duty_cycle, busy, done, exp_d, (p < 40), (p == 40));
            end
        end
        cyc();
    endtask

    task automatic test_nudges();
        host_req(4'd10);
        repeat (40) period();
        checks++;
        if ({duty_cycle, done} !== {4'd10, 1'b1}) begin
            failures++;
            $display("FAIL nudge_setup: got duty=%0d done=%b required 10/1", duty_cycle, done);
        end
        cyc();
        inc_pulse = 1'b1;
        cyc();
        inc_pulse = 1'b0;
        checks++;
        if ({duty_cycle, busy, done} !== {4'd10, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL inc_sat: got duty=%0d busy=%b done=%b required 10/0/1",
                     duty_cycle, busy, done);
        end
        cyc();
        dec_pulse = 1'b1;
        cyc();
        dec_pulse = 1'b0;
        checks++;
        if ({duty_cycle, busy} !== {4'd10, 1'b1}) begin
            failures++;
            $display("FAIL dec_accept: got duty=%0d busy=%b required 10/1", duty_cycle, busy);
        end
        repeat (4) period();
        checks++;
        if ({duty_cycle, busy, done} !== {4'd9, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL dec_step: got duty=%0d busy=%b done=%b required 9/0/1",
                     duty_cycle, busy, done);
        end
        cyc();
        inc_pulse = 1'b1;
        dec_pulse = 1'b1;
        cyc();
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        checks++;
        if ({duty_cycle, busy, done} !== {4'd9, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL inc_dec_both: got duty=%0d busy=%b done=%b required 9/0/0",
                     duty_cycle, busy, done);
        end
        // Host asks for the current duty while inc is pressed: host wins, immediate done.
        inc_pulse = 1'b1;
        host_req(4'd9);
        inc_pulse = 1'b0;
        checks++;
        if ({duty_cycle, busy, done} !== {4'd9, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL host_over_inc: got duty=%0d busy=%b done=%b required 9/0/1",
                     duty_cycle, busy, done);
        end
        cyc();
    endtask

    task automatic test_abort();
        host_req(4'd5);
        repeat (16) period();
        cyc();
        host_req(4'd9);
        repeat (8) period();
        checks++;
        if ({duty_cycle, busy} !== {4'd7, 1'b1}) begin
            failures++;
            $display("FAIL abort_setup: got duty=%0d busy=%b required 7/1", duty_cycle, busy);
        end
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if ({duty_cycle, busy, done} !== {4'd7, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort_idle: got duty=%0d busy=%b done=%b required 7/0/0",
                     duty_cycle, busy, done);
        end
        repeat (4) period();
        checks++;
        if ({duty_cycle, busy} !== {4'd7, 1'b0}) begin
            failures++;
            $display("FAIL abort_hold: got duty=%0d busy=%b required 7/0", duty_cycle, busy);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (hif.tgt_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready: got %b required 0", hif.tgt_ready);
        end
        abort = 1'b0;
        host_req(4'd7);
        checks++;
        if ({duty_cycle, busy, done} !== {4'd7, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL abort_same_tgt: got duty=%0d busy=%b done=%b required 7/0/1",
                     duty_cycle, busy, done);
        end
        cyc();
        host_req(4'd9);
        repeat (3) period();
        repeat (9) cyc();
        period_start = 1'b1;
        abort = 1'b1;
        cyc();
        period_start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({duty_cycle, busy, done} !== {4'd7, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort_step_edge: got duty=%0d busy=%b done=%b required 7/0/0",
                     duty_cycle, busy, done);
        end
    endtask

    task automatic test_busy_and_reset();
        host_req(4'd10);
        hif.tgt_valid = 1'b1;
        hif.tgt_duty  = 4'd0;
        #1;
        checks++;
        if (hif.tgt_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready: got %b required 0", hif.tgt_ready);
        end
        cyc();
        hif.tgt_valid = 1'b0;
        inc_pulse = 1'b1;
        cyc();
        inc_pulse = 1'b0;
        repeat (4) period();
        checks++;
        if ({duty_cycle, busy, done} !== {4'd8, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL busy_ignore: got duty=%0d busy=%b done=%b required 8/1/0",
                     duty_cycle, busy, done);
        end
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({duty_cycle, busy, done} !== {4'd5, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: got duty=%0d busy=%b done=%b required 5/0/0",
                     duty_cycle, busy, done);
        end
        repeat (4) period();
        checks++;
        if ({duty_cycle, busy} !== {4'd5, 1'b0}) begin
            failures++;
            $display("FAIL reset_ramp_lost: got duty=%0d busy=%b required 5/0",
                     duty_cycle, busy);
        end
    endtask

    initial begin
        hif.tgt_valid = 1'b0;
        hif.tgt_duty  = 4'd0;
        test_reset();
        test_ramp_up();
        test_ramp_down_clamp();
        test_nudges();
        test_abort();
        test_busy_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
